// File: rtl/msoc_mem_pkg.sv
// Shared types and constants for the dual-port arbitrated MSoC memory.
package msoc_mem_pkg;

    typedef logic port_id_t;

    localparam port_id_t PORT_S1 = 1'b0;
    localparam port_id_t PORT_S2 = 1'b1;

    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 2;

    function automatic int byte_lanes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/msoc_rr_arb2.sv
// Two-requester round-robin arbiter; grants are combinational from the requests
// and the priority pointer, which only moves on enabled contested cycles.
module msoc_rr_arb2
    import msoc_mem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic req1,
    input  logic req2,
    output logic grant1,
    output logic grant2
);

    port_id_t prio_q;
    port_id_t prio_d;

    always_comb begin
        grant1 = req1 & (~req2 | (prio_q == PORT_S1));
        grant2 = req2 & ~grant1;
        prio_d = prio_q;
        // The loser of a contested accept is preferred next time.
        if (en & req1 & req2) begin
            prio_d = grant1 ? PORT_S2 : PORT_S1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_q <= PORT_S1;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/msoc_dp_mem_arb.sv
// Two Avalon-MM slave ports sharing one byte-enabled single-port array, with
// round-robin arbitration and a 1- or 2-stage tagged read-return pipeline.
module msoc_dp_mem_arb
    import msoc_mem_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    DEPTH        = 23552,
    parameter int    ADDR_W       = 15,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "MSoC_mem2.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic                    reset_req,

    input  logic [ADDR_W-1:0]       s1_address,
    input  logic [DATA_W/8-1:0]     s1_byteenable,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_W-1:0]       s1_writedata,
    output logic                    s1_waitrequest,
    output logic [DATA_W-1:0]       s1_readdata,
    output logic                    s1_readdatavalid,

    input  logic [ADDR_W-1:0]       s2_address,
    input  logic [DATA_W/8-1:0]     s2_byteenable,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_W-1:0]       s2_writedata,
    output logic                    s2_waitrequest,
    output logic [DATA_W-1:0]       s2_readdata,
    output logic                    s2_readdatavalid
);

    localparam int BE_W = byte_lanes(DATA_W);

    logic en;
    logic req1;
    logic req2;
    logic grant1;
    logic grant2;

    port_id_t              sel;
    logic                  acc;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  in_range;
    logic                  wr_en;
    logic [ADDR_W-1:0]     acc_addr;
    logic [BE_W-1:0]       acc_be;
    logic [DATA_W-1:0]     acc_wdata;

    // Contents are deliberately never reset; they survive reset_n.
    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DATA_W-1:0]     ram_dat_q;

    logic                  vld_a_q;
    logic                  vld_a_d;
    port_id_t              tag_a_q;
    port_id_t              tag_a_d;

    logic                  out_vld;
    port_id_t              out_tag;
    logic [DATA_W-1:0]     out_dat;

    logic                  fire1;
    logic                  fire2;
    logic [DATA_W-1:0]     rdata1_q;
    logic [DATA_W-1:0]     rdata1_d;
    logic [DATA_W-1:0]     rdata2_q;
    logic [DATA_W-1:0]     rdata2_d;

    assign en   = clken & ~reset_req;
    assign req1 = s1_read | s1_write;
    assign req2 = s2_read | s2_write;

    assign s1_waitrequest = req1 & ~(grant1 & en);
    assign s2_waitrequest = req2 & ~(grant2 & en);

    msoc_rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .req1    (req1),
        .req2    (req2),
        .grant1  (grant1),
        .grant2  (grant2)
    );

    always_comb begin
        sel       = grant2 ? PORT_S2 : PORT_S1;
        acc       = en & (grant1 | grant2);
        acc_addr  = (sel == PORT_S2) ? s2_address    : s1_address;
        acc_be    = (sel == PORT_S2) ? s2_byteenable : s1_byteenable;
        acc_wdata = (sel == PORT_S2) ? s2_writedata  : s1_writedata;
        // read+write together on one port behaves as a plain write
        acc_wr    = acc & ((sel == PORT_S2) ? s2_write : s1_write);
        acc_rd    = acc & ((sel == PORT_S2) ? (s2_read & ~s2_write)
                                            : (s1_read & ~s1_write));
        in_range  = 32'(acc_addr) < 32'(DEPTH);
        wr_en     = acc_wr & in_range;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (acc_be[b]) begin
                    mem_q[acc_addr][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
        if (acc_rd) begin
            ram_dat_q <= in_range ? mem_q[acc_addr] : '0;
        end
    end

    always_comb begin
        vld_a_d = en ? acc_rd : vld_a_q;
        tag_a_d = en ? sel    : tag_a_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_a_q <= 1'b0;
            tag_a_q <= PORT_S1;
        end else begin
            vld_a_q <= vld_a_d;
            tag_a_q <= tag_a_d;
        end
    end

    if (READ_LATENCY == READ_LAT_MIN) begin : g_lat1
        assign out_vld = vld_a_q;
        assign out_tag = tag_a_q;
        assign out_dat = ram_dat_q;
    end else if (READ_LATENCY == READ_LAT_MAX) begin : g_lat2
        logic              vld_b_q;
        logic              vld_b_d;
        port_id_t          tag_b_q;
        port_id_t          tag_b_d;
        logic [DATA_W-1:0] dat_b_q;
        logic [DATA_W-1:0] dat_b_d;

        always_comb begin
            vld_b_d = en ? vld_a_q   : vld_b_q;
            tag_b_d = en ? tag_a_q   : tag_b_q;
            dat_b_d = en ? ram_dat_q : dat_b_q;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_b_q <= 1'b0;
                tag_b_q <= PORT_S1;
                dat_b_q <= '0;
            end else begin
                vld_b_q <= vld_b_d;
                tag_b_q <= tag_b_d;
                dat_b_q <= dat_b_d;
            end
        end

        assign out_vld = vld_b_q;
        assign out_tag = tag_b_q;
        assign out_dat = dat_b_q;
    end

    // A pending return is only presented in an enabled cycle, so a stall
    // defers the pulse instead of repeating it.
    always_comb begin
        fire1    = en & out_vld & (out_tag == PORT_S1);
        fire2    = en & out_vld & (out_tag == PORT_S2);
        rdata1_d = fire1 ? out_dat : rdata1_q;
        rdata2_d = fire2 ? out_dat : rdata2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign s1_readdatavalid = fire1;
    assign s2_readdatavalid = fire2;
    assign s1_readdata      = rdata1_d;
    assign s2_readdata      = rdata2_d;

endmodule

// File: tb/tb_msoc_dp_mem_arb.sv
// Drives one stimulus stream into a latency-1 and a latency-2 instance and
// checks both against a transaction-level model of memory, arbitration and returns.
module tb_msoc_dp_mem_arb;

    localparam int DW    = 32;
    localparam int AW    = 15;
    localparam int DEPTH = 23552;

    logic clk = 1'b0;
    logic reset_n;
    logic clken;
    logic reset_req;

    logic [AW-1:0] s1_address, s2_address;
    logic [3:0]    s1_byteenable, s2_byteenable;
    logic          s1_read, s1_write, s2_read, s2_write;
    logic [DW-1:0] s1_writedata, s2_writedata;

    logic          s1_wait [2];
    logic          s2_wait [2];
    logic          s1_rdv  [2];
    logic          s2_rdv  [2];
    logic [DW-1:0] s1_rd   [2];
    logic [DW-1:0] s2_rd   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        msoc_dp_mem_arb #(
            .DATA_W       (DW),
            .DEPTH        (DEPTH),
            .ADDR_W       (AW),
            .READ_LATENCY (g + 1),
            .INIT_FILE    ("")
        ) u_dut (
            .clk              (clk),
            .reset_n          (reset_n),
            .clken            (clken),
            .reset_req        (reset_req),
            .s1_address       (s1_address),
            .s1_byteenable    (s1_byteenable),
            .s1_read          (s1_read),
            .s1_write         (s1_write),
            .s1_writedata     (s1_writedata),
            .s1_waitrequest   (s1_wait[g]),
            .s1_readdata      (s1_rd[g]),
            .s1_readdatavalid (s1_rdv[g]),
            .s2_address       (s2_address),
            .s2_byteenable    (s2_byteenable),
            .s2_read          (s2_read),
            .s2_write         (s2_write),
            .s2_writedata     (s2_writedata),
            .s2_waitrequest   (s2_wait[g]),
            .s2_readdata      (s2_rd[g]),
            .s2_readdatavalid (s2_rdv[g])
        );
    end

    // Reference model: word memory, who won the last contested cycle, a log of
    // accepted reads stamped with their enabled-cycle index, per-instance cursors.
    typedef struct {
        int          port;
        logic [31:0] dat;
        int          n;
    } rd_t;

    rd_t         acc_q[$];
    int          head [2];
    logic [31:0] hold1 [2];
    logic [31:0] hold2 [2];
    logic [31:0] mem_m [32];
    int          last_winner;
    int          ecount;
    int          n_cmp;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input bit rd, input bit wr, input int addr,
                         input logic [3:0] be, input logic [31:0] wd);
        if (p == 1) begin
            s1_read = rd; s1_write = wr; s1_address = AW'(addr);
            s1_byteenable = be; s1_writedata = wd;
        end else begin
            s2_read = rd; s2_write = wr; s2_address = AW'(addr);
            s2_byteenable = be; s2_writedata = wd;
        end
    endtask

    task automatic idle();
        drive(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        drive(2, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    endtask

    task automatic model_flush();
        head[0] = acc_q.size();
        head[1] = acc_q.size();
        for (int d = 0; d < 2; d++) begin
            hold1[d] = 32'h0;
            hold2[d] = 32'h0;
        end
        last_winner = 2;
    endtask

    // Winner under round-robin: lone requester wins; on contention the port
    // that did not win the previous contested accept wins.
    function automatic int winner(input bit r1, input bit r2);
        if (r1 && r2) return (last_winner == 1) ? 2 : 1;
        if (r1) return 1;
        if (r2) return 2;
        return 0;
    endfunction

    task automatic check_cycle();
        bit en_m, r1, r2, v1, v2;
        int w;
        en_m = clken && !reset_req;
        r1 = s1_read || s1_write;
        r2 = s2_read || s2_write;
        w  = winner(r1, r2);
        for (int d = 0; d < 2; d++) begin
            v1 = 1'b0;
            v2 = 1'b0;
            // latency L = d+1: a read accepted at enabled edge n returns in the
            // enabled cycle that ends with enabled edge n+L
            if (reset_n && en_m && head[d] < acc_q.size() &&
                acc_q[head[d]].n + d == ecount) begin
                if (acc_q[head[d]].port == 1) begin
                    v1 = 1'b1;
                    hold1[d] = acc_q[head[d]].dat;
                end else begin
                    v2 = 1'b1;
                    hold2[d] = acc_q[head[d]].dat;
                end
                head[d]++;
            end
            chk($sformatf("L%0d s1_waitrequest", d + 1), 32'(s1_wait[d]), 32'(r1 && !(w == 1 && en_m)));
            chk($sformatf("L%0d s2_waitrequest", d + 1), 32'(s2_wait[d]), 32'(r2 && !(w == 2 && en_m)));
            chk($sformatf("L%0d s1_readdatavalid", d + 1), 32'(s1_rdv[d]), 32'(v1));
            chk($sformatf("L%0d s2_readdatavalid", d + 1), 32'(s2_rdv[d]), 32'(v2));
            chk($sformatf("L%0d s1_readdata", d + 1), s1_rd[d], hold1[d]);
            chk($sformatf("L%0d s2_readdata", d + 1), s2_rd[d], hold2[d]);
        end
    endtask

    task automatic model_edge();
        bit r1, r2, wr;
        int w, addr;
        logic [3:0]  be;
        logic [31:0] wd;
        if (!reset_n || !clken || reset_req) return;
        ecount++;
        r1 = s1_read || s1_write;
        r2 = s2_read || s2_write;
        w  = winner(r1, r2);
        if (w == 0) return;
        if (r1 && r2) last_winner = w;
        addr = (w == 1) ? int'(s1_address)    : int'(s2_address);
        be   = (w == 1) ? s1_byteenable       : s2_byteenable;
        wd   = (w == 1) ? s1_writedata        : s2_writedata;
        wr   = (w == 1) ? s1_write            : s2_write;
        if (wr) begin
            if (addr < DEPTH) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem_m[addr % 32][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end else begin
            acc_q.push_back('{port: w,
                              dat: (addr < DEPTH) ? mem_m[addr % 32] : 32'h0,
                              n: ecount});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a1, a2;
        n_cmp = 0;
        n_fail = 0;
        ecount = 0;
        for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
        model_flush();

        reset_n = 1'b0;
        clken = 1'b1;
        reset_req = 1'b0;
        idle();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Preload every address the bench will read in range.
        for (int a = 0; a < 18; a++) begin
            drive(1, 1'b0, 1'b1, a, 4'hF, $urandom);
            tick();
        end
        idle();

        // s1 write then s2 read of the same word in the next cycle.
        drive(1, 1'b0, 1'b1, 16, 4'hF, 32'hDEADBEEF);
        tick();
        idle();
        drive(2, 1'b1, 1'b0, 16, 4'h0, 32'h0);
        tick();
        idle();
        repeat (3) tick();
        chk("raw_deadbeef_l1", s2_rd[0], 32'hDEADBEEF);
        chk("raw_deadbeef_l2", s2_rd[1], 32'hDEADBEEF);

        // Both ports reading every cycle: alternate grants, ordered returns.
        drive(1, 1'b1, 1'b0, 1, 4'h0, 32'h0);
        drive(2, 1'b1, 1'b0, 2, 4'h0, 32'h0);
        repeat (8) tick();
        idle();
        repeat (3) tick();

        // Partial byte-lane write merge.
        drive(1, 1'b0, 1'b1, 17, 4'hF, 32'h11223344);
        tick();
        drive(1, 1'b0, 1'b1, 17, 4'b0101, 32'hAABBCCDD);
        tick();
        idle();
        drive(2, 1'b1, 1'b0, 17, 4'h0, 32'h0);
        tick();
        idle();
        repeat (3) tick();
        chk("byte_merge", s2_rd[0], 32'h11BB33DD);

        // Out-of-range read returns zeros; out-of-range write is dropped.
        drive(1, 1'b1, 1'b0, DEPTH, 4'h0, 32'h0);
        tick();
        idle();
        repeat (3) tick();
        chk("oor_read_zero", s1_rd[1], 32'h0);
        drive(1, 1'b0, 1'b1, DEPTH, 4'hF, 32'hFFFFFFFF);
        tick();
        drive(1, 1'b1, 1'b0, 0, 4'h0, 32'h0);
        tick();
        idle();
        repeat (3) tick();

        // Clock-enable stall right after a read accept.
        drive(1, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        tick();
        clken = 1'b0;
        drive(1, 1'b1, 1'b0, 6, 4'h0, 32'h0);
        drive(2, 1'b0, 1'b1, 7, 4'hF, 32'h0BADF00D);
        repeat (3) tick();
        clken = 1'b1;
        idle();
        repeat (4) tick();

        // Reset with two reads in flight.
        drive(1, 1'b1, 1'b0, 3, 4'h0, 32'h0);
        tick();
        drive(2, 1'b1, 1'b0, 4, 4'h0, 32'h0);
        tick();
        idle();
        reset_n = 1'b0;
        model_flush();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        drive(1, 1'b1, 1'b0, 16, 4'h0, 32'h0);
        tick();
        drive(1, 1'b1, 1'b0, 17, 4'h0, 32'h0);
        tick();
        idle();
        repeat (3) tick();
        chk("after_reset_17", s1_rd[0], 32'h11BB33DD);

        // Randomized traffic with occasional stalls and out-of-range addresses.
        for (int i = 0; i < 400; i++) begin
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 14) == 0);
            a1 = ($urandom_range(0, 15) == 0) ? DEPTH + int'($urandom_range(0, 5)) : int'($urandom_range(0, 17));
            a2 = ($urandom_range(0, 15) == 0) ? DEPTH + int'($urandom_range(0, 5)) : int'($urandom_range(0, 17));
            drive(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a1, 4'($urandom), $urandom);
            drive(2, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a2, 4'($urandom), $urandom);
            tick();
        end
        clken = 1'b1;
        reset_req = 1'b0;
        idle();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
